// File: rtl/mem_level.sv
// Memory stage: data memory with byte/halfword lanes, load extension and the MEM/WB pipeline register.
// Instruction IDs and widths shared with the other stages live in mem_level_pkg.
package mem_level_pkg;
  localparam int WIDTH_INSTR = 6;
  localparam int WIDTH_T     = 2;

  typedef logic [WIDTH_INSTR-1:0] instr_t;

  localparam instr_t I_NOP  = 6'd0;
  localparam instr_t I_ADDU = 6'd1;
  localparam instr_t I_SUBU = 6'd2;
  localparam instr_t I_ORI  = 6'd3;
  localparam instr_t I_LUI  = 6'd4;
  localparam instr_t I_LW   = 6'd5;
  localparam instr_t I_LH   = 6'd6;
  localparam instr_t I_LHU  = 6'd7;
  localparam instr_t I_LB   = 6'd8;
  localparam instr_t I_LBU  = 6'd9;
  localparam instr_t I_SW   = 6'd10;
  localparam instr_t I_SH   = 6'd11;
  localparam instr_t I_SB   = 6'd12;
  localparam instr_t I_BEQ  = 6'd13;
  localparam instr_t I_JAL  = 6'd14;

  typedef struct packed {
    instr_t               instr;
    logic [31:0]          pc;
    logic [4:0]           addr;
    logic [31:0]          data;
    logic [WIDTH_T-1:0]   tnew;
  } wb_t;
endpackage

// One byte lane of the store path: decides whether this lane is written and with which byte.
module mem_level_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] boff,
  input  logic       is_sw,
  input  logic       is_sh,
  input  logic       is_sb,
  input  logic [7:0] b_sw,
  input  logic [7:0] b_sh,
  input  logic [7:0] b_sb,
  output logic       we,
  output logic [7:0] wbyte
);
  localparam logic [1:0] L = 2'(LANE);

  always_comb begin
    we    = 1'b0;
    wbyte = b_sw;
    if (is_sw) begin
      we    = 1'b1;
      wbyte = b_sw;
    end else if (is_sh) begin
      we    = (boff[1] == L[1]);
      wbyte = b_sh;
    end else if (is_sb) begin
      we    = (boff == L);
      wbyte = b_sb;
    end
  end
endmodule

module mem_level
  import mem_level_pkg::*;
#(
  parameter int DM_WORDS = 4096,
  parameter int ADDR_LSB = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   clr,
  input  logic [WIDTH_INSTR-1:0] instr_MEM,
  input  logic [31:0]            PC_MEM,
  input  logic [31:0]            aluOut_MEM,
  input  logic [31:0]            memWriteData_MEM,
  input  logic [4:0]             addrRt_MEM,
  input  logic [4:0]             regWriteAddr_MEM,
  input  logic [31:0]            regWriteData_MEM,
  input  logic [WIDTH_T-1:0]     Tnew_MEM,
  input  logic [4:0]             regaddr_WB,
  input  logic [31:0]            regdata_WB,
  output logic [WIDTH_INSTR-1:0] instr_WB,
  output logic [31:0]            PC_WB,
  output logic [4:0]             regWriteAddr_WB,
  output logic [31:0]            regWriteData_WB,
  output logic [WIDTH_T-1:0]     Tnew_WB,
  output logic [4:0]             regaddr_MEM,
  output logic [31:0]            regdata_MEM
);
  localparam int NUM_LANES = 4;
  localparam int AW        = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

  logic [31:0]   dmem [DM_WORDS];
  logic [11:0]   word_field;
  logic [AW-1:0] idx;
  logic [1:0]    boff;
  logic          unused_addr;

  // DM_WORDS is a power of two no larger than 4096, so the modulo is a truncation.
  assign word_field  = aluOut_MEM[ADDR_LSB+11:ADDR_LSB];
  assign idx         = word_field[AW-1:0];
  assign boff        = aluOut_MEM[1:0];
  assign unused_addr = ^{aluOut_MEM[31:ADDR_LSB+12], word_field};

  logic is_sw, is_sh, is_sb, is_load;
  assign is_sw   = (instr_MEM == I_SW);
  assign is_sh   = (instr_MEM == I_SH);
  assign is_sb   = (instr_MEM == I_SB);
  assign is_load = (instr_MEM == I_LW) || (instr_MEM == I_LH) || (instr_MEM == I_LHU) ||
                   (instr_MEM == I_LB) || (instr_MEM == I_LBU);

  // The store's rt may be written back this very cycle; take the fresh value.
  logic [31:0] sdata;
  assign sdata = (regaddr_WB == addrRt_MEM && regaddr_WB != 5'd0) ? regdata_WB : memWriteData_MEM;

  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] wbytes;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_level_lane #(.LANE(i)) u_lane (
      .boff  (boff),
      .is_sw (is_sw),
      .is_sh (is_sh),
      .is_sb (is_sb),
      .b_sw  (sdata[8*i +: 8]),
      .b_sh  (sdata[8*(i%2) +: 8]),
      .b_sb  (sdata[7:0]),
      .we    (be[i]),
      .wbyte (wbytes[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < DM_WORDS; w++) dmem[w] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (be[i]) dmem[idx][8*i +: 8] <= wbytes[i];
    end
  end

  logic [31:0] rword;
  logic [15:0] rhalf;
  logic [7:0]  rbyte;
  logic [31:0] ld_ext;

  assign rword = dmem[idx];
  assign rhalf = boff[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    rbyte = rword[7:0];
    case (boff)
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      2'd3:    rbyte = rword[31:24];
      default: rbyte = rword[7:0];
    endcase
  end

  always_comb begin
    ld_ext = rword;
    case (instr_MEM)
      I_LH:    ld_ext = {{16{rhalf[15]}}, rhalf};
      I_LHU:   ld_ext = {16'b0, rhalf};
      I_LB:    ld_ext = {{24{rbyte[7]}}, rbyte};
      I_LBU:   ld_ext = {24'b0, rbyte};
      default: ld_ext = rword;
    endcase
  end

  logic [WIDTH_T-1:0] tnew_dec;
  assign tnew_dec = (Tnew_MEM == '0) ? '0 : Tnew_MEM - WIDTH_T'(1);

  wb_t wb_nxt;
  wb_t wb_q = '0;

  always_comb begin
    wb_nxt       = '0;
    wb_nxt.instr = instr_MEM;
    wb_nxt.pc    = PC_MEM;
    wb_nxt.addr  = regWriteAddr_MEM;
    wb_nxt.data  = is_load ? ld_ext : regWriteData_MEM;
    wb_nxt.tnew  = tnew_dec;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) wb_q <= '0;
    else if (!stall)  wb_q <= wb_nxt;
  end

  assign instr_WB        = wb_q.instr;
  assign PC_WB           = wb_q.pc;
  assign regWriteAddr_WB = wb_q.addr;
  assign regWriteData_WB = wb_q.data;
  assign Tnew_WB         = wb_q.tnew;

  // Load data is never forwarded from here; hazard logic stalls consumers instead.
  assign regaddr_MEM = regWriteAddr_MEM;
  assign regdata_MEM = regWriteData_MEM;
endmodule

// File: tb/tb_mem_level.sv
// Random + directed bench for mem_level against a byte-address memory model.
module tb_mem_level;
  import mem_level_pkg::*;

  logic clk = 1'b0;
  logic reset, stall, clr;
  logic [WIDTH_INSTR-1:0] instr_MEM;
  logic [31:0] PC_MEM, aluOut_MEM, memWriteData_MEM, regWriteData_MEM, regdata_WB;
  logic [4:0]  addrRt_MEM, regWriteAddr_MEM, regaddr_WB;
  logic [WIDTH_T-1:0] Tnew_MEM;
  logic [WIDTH_INSTR-1:0] instr_WB;
  logic [31:0] PC_WB, regWriteData_WB, regdata_MEM;
  logic [4:0]  regWriteAddr_WB, regaddr_MEM;
  logic [WIDTH_T-1:0] Tnew_WB;

  int vectors = 0;
  int miscompares = 0;

  mem_level dut (
    .clk(clk), .reset(reset), .stall(stall), .clr(clr),
    .instr_MEM(instr_MEM), .PC_MEM(PC_MEM), .aluOut_MEM(aluOut_MEM),
    .memWriteData_MEM(memWriteData_MEM), .addrRt_MEM(addrRt_MEM),
    .regWriteAddr_MEM(regWriteAddr_MEM), .regWriteData_MEM(regWriteData_MEM),
    .Tnew_MEM(Tnew_MEM), .regaddr_WB(regaddr_WB), .regdata_WB(regdata_WB),
    .instr_WB(instr_WB), .PC_WB(PC_WB), .regWriteAddr_WB(regWriteAddr_WB),
    .regWriteData_WB(regWriteData_WB), .Tnew_WB(Tnew_WB),
    .regaddr_MEM(regaddr_MEM), .regdata_MEM(regdata_MEM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: word array indexed from the byte address ----
  logic [31:0] mm [4096];
  logic [31:0] e_instr = 0, e_pc = 0, e_data = 0, e_addr = 0, e_tnew = 0;

  initial for (int w = 0; w < 4096; w++) mm[w] = 0;

  always @(posedge clk) begin
    int unsigned a, wi, sh, t;
    logic [31:0] word, d, v, mask;
    a  = aluOut_MEM;
    wi = (a / 4) % 4096;
    word = mm[wi];
    v = regWriteData_MEM;
    case (instr_MEM)
      I_LW:  v = word;
      I_LBU: v = (word >> (8 * (a % 4))) & 32'hFF;
      I_LB:  begin v = (word >> (8 * (a % 4))) & 32'hFF; if (v >= 128) v = v | 32'hFFFFFF00; end
      I_LHU: v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      I_LH:  begin v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF; if (v >= 32768) v = v | 32'hFFFF0000; end
      default: ;
    endcase
    d = (regaddr_WB == addrRt_MEM && regaddr_WB != 0) ? regdata_WB : memWriteData_MEM;
    if (reset) begin
      for (int w = 0; w < 4096; w++) mm[w] = 0;
    end else if (instr_MEM == I_SW) begin
      mm[wi] = d;
    end else if (instr_MEM == I_SH) begin
      sh = 16 * ((a / 2) % 2);
      mask = 32'hFFFF << sh;
      mm[wi] = (word & ~mask) | ((d & 32'hFFFF) << sh);
    end else if (instr_MEM == I_SB) begin
      sh = 8 * (a % 4);
      mask = 32'hFF << sh;
      mm[wi] = (word & ~mask) | ((d & 32'hFF) << sh);
    end
    t = Tnew_MEM;
    if (reset || clr) begin
      e_instr = 0; e_pc = 0; e_addr = 0; e_data = 0; e_tnew = 0;
    end else if (!stall) begin
      e_instr = instr_MEM; e_pc = PC_MEM; e_addr = regWriteAddr_MEM; e_data = v;
      e_tnew = (t > 0) ? t - 1 : 0;
    end
  end

  // ---- single compare process ----
  always @(negedge clk) begin
    chk("instr_WB", 32'(instr_WB), e_instr);
    chk("PC_WB", PC_WB, e_pc);
    chk("regWriteAddr_WB", 32'(regWriteAddr_WB), e_addr);
    chk("regWriteData_WB", regWriteData_WB, e_data);
    chk("Tnew_WB", 32'(Tnew_WB), e_tnew);
    chk("regaddr_MEM", 32'(regaddr_MEM), 32'(regWriteAddr_MEM));
    chk("regdata_MEM", regdata_MEM, regWriteData_MEM);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input instr_t ins, input logic [31:0] addr, input logic [31:0] mwd,
                    input logic [4:0] rd, input logic [31:0] rdata, input logic [WIDTH_T-1:0] tn);
    instr_MEM = ins; aluOut_MEM = addr; memWriteData_MEM = mwd;
    regWriteAddr_MEM = rd; regWriteData_MEM = rdata; Tnew_MEM = tn;
    PC_MEM = 32'h3000 + addr;
  endtask

  task automatic ld(input instr_t ins, input logic [31:0] addr, input logic [31:0] exp, input string name);
    op(ins, addr, 0, 5'd2, 32'h0, 2'd2);
    tick();
    chk(name, regWriteData_WB, exp);
  endtask

  instr_t ops [15] = '{I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_LH, I_LHU,
                       I_LB, I_LBU, I_SW, I_SH, I_SB, I_BEQ, I_JAL};

  initial begin
    reset = 1; stall = 0; clr = 0;
    addrRt_MEM = 1; regaddr_WB = 0; regdata_WB = 0;
    op(I_NOP, 0, 0, 0, 0, 0);
    #1;
    chk("powerup_addr", 32'(regWriteAddr_WB), 0);
    chk("powerup_data", regWriteData_WB, 0);
    tick(); tick();
    reset = 0;

    op(I_SW, 32'h10, 32'h8899AABB, 0, 0, 0); tick();
    ld(I_LW, 32'h10, 32'h8899AABB, "lw_0x10");
    chk("lw_tnew", 32'(Tnew_WB), 1);
    op(I_SB, 32'h11, 32'h000000CC, 0, 0, 0); tick();
    ld(I_LB,  32'h11, 32'hFFFFFFCC, "lb_0x11");
    ld(I_LBU, 32'h11, 32'h000000CC, "lbu_0x11");
    ld(I_LW,  32'h10, 32'h8899CCBB, "lw_after_sb");
    op(I_SH, 32'h12, 32'h00001234, 0, 0, 0); tick();
    ld(I_LH,  32'h12, 32'h00001234, "lh_0x12");
    ld(I_LHU, 32'h10, 32'h0000CCBB, "lhu_0x10");
    ld(I_LH,  32'h10, 32'hFFFFCCBB, "lh_0x10");
    ld(I_LW,  32'h13, 32'h1234CCBB, "lw_misaligned");

    addrRt_MEM = 5; regaddr_WB = 5; regdata_WB = 32'hDEADBEEF;
    op(I_SW, 32'h20, 32'h0, 0, 0, 0); tick();
    regaddr_WB = 0;
    ld(I_LW, 32'h20, 32'hDEADBEEF, "sw_fwd_wb");
    op(I_SW, 32'h20, 32'h0, 0, 0, 0); tick();
    ld(I_LW, 32'h20, 32'h0, "sw_no_fwd_r0");
    addrRt_MEM = 1; regdata_WB = 0;

    op(I_ADDU, 0, 0, 5'd9, 32'h11, 2'd1); tick();
    chk("addu_data", regWriteData_WB, 32'h11);
    stall = 1;
    op(I_ADDU, 0, 0, 5'd3, 32'd7, 2'd2); tick();
    chk("stall1_addr", 32'(regWriteAddr_WB), 9);
    tick();
    chk("stall2_data", regWriteData_WB, 32'h11);
    stall = 0; tick();
    chk("release_addr", 32'(regWriteAddr_WB), 3);
    chk("release_data", regWriteData_WB, 7);
    chk("release_tnew", 32'(Tnew_WB), 1);
    clr = 1; tick(); clr = 0;
    chk("clr_data", regWriteData_WB, 0);
    chk("clr_pc", PC_WB, 0);
    chk("clr_tnew", 32'(Tnew_WB), 0);

    op(I_SW, 32'h4000, 32'h55, 0, 0, 0); tick();
    ld(I_LW, 32'h0, 32'h55, "wrap_0x4000");
    reset = 1;
    op(I_SW, 32'h30, 32'hABCD1234, 0, 0, 0); tick();
    reset = 0;
    ld(I_LW, 32'h30, 32'h0, "reset_store");
    ld(I_LW, 32'h10, 32'h0, "reset_clears_mem");

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) a = a | ($urandom << 14);
      op(ops[$urandom_range(0, 14)], a, $urandom, 5'($urandom), $urandom, WIDTH_T'($urandom));
      addrRt_MEM = 5'($urandom);
      regaddr_WB = ($urandom_range(0, 1) == 0) ? addrRt_MEM : 5'($urandom);
      regdata_WB = $urandom;
      stall = ($urandom_range(0, 7) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 0; stall = 0; clr = 0;
    op(I_NOP, 0, 0, 0, 0, 0);
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_level.md
MEM_LEVEL -- requirements
Module: mem_level

Interface
REQ-001 SHALL define parameter DM_WORDS, default 4096, number of 32-bit words in data memory.
REQ-002 SHALL define parameter ADDR_LSB, default 2, byte-offset bits dropped to form the word index.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold WB pipeline registers
- clr  in  1  load bubble (zeros) into WB registers
- instr_MEM  in  WIDTH_INSTR  decoded instruction ID (shared instruction definitions)
- PC_MEM  in  32  instruction PC
- aluOut_MEM  in  32  byte address for loads/stores; result for other instructions
- memWriteData_MEM  in  32  store data, before WB forwarding
- addrRt_MEM  in  5  rt register number of the store
- regWriteAddr_MEM  in  5  destination register, 0 = none
- regWriteData_MEM  in  32  destination data already produced
- Tnew_MEM  in  WIDTH_T  cycles until result ready
- regaddr_WB  in  5  register written back this cycle
- regdata_WB  in  32  data written back this cycle
- instr_WB, PC_WB  out  WIDTH_INSTR, 32  registered copies
- regWriteAddr_WB  out  5  registered destination
- regWriteData_WB  out  32  registered final write data
- Tnew_WB  out  WIDTH_T  registered Tnew
- regaddr_MEM, regdata_MEM  out  5, 32  combinational forward source for EX/ID

Function
REQ-004 Word index SHALL be aluOut_MEM[ADDR_LSB+11:ADDR_LSB], taken modulo DM_WORDS. Upper address bits SHALL be ignored, so addresses wrap.
REQ-005 Store data SHALL be forwarded from WB: if regaddr_WB==addrRt_MEM and regaddr_WB!=0, use regdata_WB; otherwise use memWriteData_MEM.
REQ-006 SW SHALL write the full word. SH SHALL write halfword addr[1] (0 = bits 15:0, 1 = bits 31:16) with data[15:0]. SB SHALL write byte addr[1:0] (0 = bits 7:0 … 3 = bits 31:24) with data[7:0]. Bytes not selected are unchanged.
REQ-007 Memory writes SHALL occur on the rising edge when a store is present and reset=0. Writes SHALL NOT depend on stall or clr. A repeated store while stalled is idempotent.
REQ-008 Memory reads SHALL be combinational from the array (zero latency). A load issued in the cycle after a store to the same word SHALL return the new value.
REQ-009 LW SHALL return the word. LH/LHU SHALL select the halfword by addr[1], then sign-/zero-extend. LB/LBU SHALL select the byte by addr[1:0], then sign-/zero-extend.
REQ-010 Misaligned addresses SHALL NOT raise an exception. Offset bits below the access size SHALL be ignored (e.g. LW at 0x...3 reads the word at 0x...0).
REQ-011 Final write data SHALL be the extended load data for loads, and regWriteData_MEM otherwise.
REQ-012 regaddr_MEM SHALL equal regWriteAddr_MEM.
REQ-013 regdata_MEM SHALL equal regWriteData_MEM. Load data SHALL NOT be forwarded from MEM; hazard logic stalls for it.
REQ-014 Tnew passed to WB SHALL be Tnew_MEM-1, saturating at 0.
REQ-015 WB registers SHALL update on the rising edge with priority reset|clr (all zero) > stall (hold) > load.
REQ-016 A non-memory instruction SHALL leave memory unchanged and pass regWriteData_MEM through.

Reset
REQ-017 On reset, all WB outputs SHALL be 0 and every memory word SHALL be 0, effective at the next edge.
REQ-018 Power-up values of all WB outputs SHALL be 0.
REQ-019 A store coinciding with reset SHALL NOT write.
REQ-020 Reset asserted mid-operation SHALL discard the in-flight instruction; the next valid instruction after deassertion SHALL behave normally.

Verification
REQ-021 SW addr 0x10 data 0x8899AABB, then LW 0x10 next cycle -> regWriteData_WB=0x8899AABB.
REQ-022 After REQ-021: SB addr 0x11 data 0x000000CC, then LB 0x11 -> 0xFFFFFFCC; LBU 0x11 -> 0x000000CC; LW 0x10 -> 0x8899CCBB.
REQ-023 After REQ-022: SH addr 0x12 data 0x00001234, then LH 0x12 -> 0x00001234; LHU 0x10 -> 0x0000CCBB; LH 0x10 -> 0xFFFFCCBB.
REQ-024 SW addr 0x20 with addrRt_MEM=5, regaddr_WB=5, regdata_WB=0xDEADBEEF, memWriteData_MEM=0 -> memory word 0x20 = 0xDEADBEEF. Repeat with regaddr_WB=0 -> word 0x20 = 0.
REQ-025 stall=1 for 2 cycles with ADDU to reg 3, data 7, Tnew_MEM=2 -> WB outputs hold old values. On release -> regWriteAddr_WB=3, regWriteData_WB=7, Tnew_WB=1. clr=1 -> all WB outputs 0.
REQ-026 SW addr 0x4000 data 0x55 -> word index 0 written (wrap). Reset asserted together with a store to 0x30 -> word 0x30 reads 0 after reset.
